dbus_ram_responder: RTL



---
 rtl/common.sv | 18 +
 rtl/dbus_resp_pkg.sv | 16 +
 rtl/dbus_ram_responder_strobe_ram.sv | 31 +++
 rtl/dbus_ram_responder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared data-bus request/response types used by the core and its data-side responders.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_resp_pkg.sv
// State encoding and constants shared by the data-bus RAM responder.
package dbus_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } resp_state_t;

    localparam int unsigned LAT_W = 4;

    // Fibonacci LFSR, taps 16,14,13,11 expressed as a feedback mask on bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dbus_ram_responder_strobe_ram.sv
// DEPTH_WORDS x 64 storage with byte-strobed synchronous write and registered read.
module strobe_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_strobe,
    input  logic [63:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_strobe[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/dbus_ram_responder.sv
// Data-bus responder backed by a byte-strobed RAM with programmable access latency.
// Define DBUS_RESP_RANDLAT_EN to add 0..3 LFSR-driven extra cycles per transaction.
module dbus_ram_responder
    import common::*;
    import dbus_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
`ifdef DBUS_RESP_RANDLAT_EN
    localparam int unsigned CNT_W = LAT_W + 1;
`else
    localparam int unsigned CNT_W = LAT_W;
`endif

    resp_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             in_range_q;
    logic [7:0]       strobe_q;
    logic [63:0]      wdata_q;
    logic             rd_valid_q;

    logic [63:0]      offset;
    logic [IDX_W-1:0] req_idx;
    logic             req_in_range;
    logic [CNT_W-1:0] lat_eff;
    logic             accept;
    logic             load_rd;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_en;
    logic [63:0]      ram_rdata;
    logic             unused_bits;

    assign offset       = dreq.addr - BASE_ADDR;
    assign req_idx      = offset[3 +: IDX_W];
    assign req_in_range = (dreq.addr >= BASE_ADDR) && (offset[63:3] < 61'(DEPTH_WORDS));
    assign unused_bits  = ^{dreq.size, offset[2:0]};

`ifdef DBUS_RESP_RANDLAT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign lat_eff = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign lat_eff = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        load_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dreq.valid) begin
                    accept = 1'b1;
                    if (lat_eff == CNT_W'(1)) begin
                        state_d = StResp;
                        load_rd = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = lat_eff - CNT_W'(2);
                    end
                end
            end
            StBusy: begin
                // Initiator withdrew the request: abandon it without a handshake.
                if (!dreq.valid) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StResp;
                    load_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Single-cycle path reads with the live request; otherwise use the latched one.
    assign rd_idx      = (state_q == StIdle) ? req_idx : idx_q;
    assign rd_in_range = (state_q == StIdle) ? req_in_range : in_range_q;
    assign wr_en       = (state_q == StResp) && in_range_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            strobe_q   <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q      <= req_idx;
                in_range_q <= req_in_range;
                strobe_q   <= dreq.strobe;
                wdata_q    <= dreq.data;
            end
            if (load_rd) begin
                rd_valid_q <= rd_in_range;
            end
        end
    end

    strobe_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_strobe(strobe_q),
        .wr_data  (wdata_q),
        .rd_en    (load_rd && rd_in_range),
        .rd_idx   (rd_idx),
        .rd_data  (ram_rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state_q == StResp);
        dresp.data_ok = (state_q == StResp);
        dresp.data    = rd_valid_q ? ram_rdata : '0;
    end

endmodule
